// File: rtl/game_ctl.sv
// Pong-style match controller: sequences serve, play, pause and point scoring
// for a two-player game, with every output driven straight from a flop.
module game_ctl #(
  parameter int WIN_SCORE   = 5,
  parameter int SCORE_W     = 4,
  parameter int SERVE_DELAY = 60,
  parameter int PAUSE_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [2:0]         state,
  output logic               ball_enable,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner
);

  localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0]   DELAY = CNT_W'(SERVE_DELAY);
  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               start_prev_q, pause_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               credit_left_q, credit_left_d;
  logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
  logic [1:0]         win_q, win_d;
  logic               dir_q, dir_d, be_q, be_d, br_q, br_d;
  logic               start_edge, pause_edge;

  // Delayed copies reset to 1 so a button held through reset is not an edge.
  assign start_edge = start_btn & ~start_prev_q;
  assign pause_edge = pause_btn & ~pause_prev_q & (PAUSE_EN != 0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    credit_left_d = credit_left_q;
    sl_d          = sl_q;
    sr_d          = sr_q;
    win_d         = win_q;
    dir_d         = dir_q;
    case (state_q)
      S_IDLE: begin
        sl_d  = '0;
        sr_d  = '0;
        win_d = 2'b00;
        if (start_edge) begin
          state_d = S_SERVE;
          dir_d   = 1'b1;
        end
      end
      S_SERVE: begin
        cnt_d = cnt_q;
        if (cnt_q == DELAY) state_d = S_PLAY;
        else if (frame_tick) cnt_d = cnt_q + 1'b1;
      end
      S_PLAY: begin
        // A simultaneous double miss is a replay; any miss beats pause.
        if (miss_left && miss_right) begin
          state_d = S_SERVE;
        end else if (miss_left) begin
          state_d       = S_POINT;
          credit_left_d = 1'b0;
        end else if (miss_right) begin
          state_d       = S_POINT;
          credit_left_d = 1'b1;
        end else if (pause_edge) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_edge) state_d = S_PLAY;
      end
      S_POINT: begin
        if (credit_left_q) begin
          dir_d = 1'b1;
          if (sl_q < WIN) sl_d = sl_q + 1'b1;
          if (sl_d == WIN) begin
            state_d = S_OVER;
            win_d   = 2'b01;
          end else begin
            state_d = S_SERVE;
          end
        end else begin
          dir_d = 1'b0;
          if (sr_q < WIN) sr_d = sr_q + 1'b1;
          if (sr_d == WIN) begin
            state_d = S_OVER;
            win_d   = 2'b10;
          end else begin
            state_d = S_SERVE;
          end
        end
      end
      S_OVER: begin
        if (start_edge) begin
          state_d = S_SERVE;
          sl_d    = '0;
          sr_d    = '0;
          win_d   = 2'b00;
          dir_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Ball controls are registered from the next state so they track state.
    be_d = (state_d == S_PLAY);
    br_d = !((state_d == S_PLAY) || (state_d == S_PAUSE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_prev_q  <= 1'b1;
      pause_prev_q  <= 1'b1;
      cnt_q         <= '0;
      credit_left_q <= 1'b0;
      sl_q          <= '0;
      sr_q          <= '0;
      win_q         <= 2'b00;
      dir_q         <= 1'b1;
      be_q          <= 1'b0;
      br_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_btn;
      pause_prev_q  <= pause_btn;
      cnt_q         <= cnt_d;
      credit_left_q <= credit_left_d;
      sl_q          <= sl_d;
      sr_q          <= sr_d;
      win_q         <= win_d;
      dir_q         <= dir_d;
      be_q          <= be_d;
      br_q          <= br_d;
    end
  end

  assign state       = state_q;
  assign ball_enable = be_q;
  assign ball_reset  = br_q;
  assign serve_dir   = dir_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: a vector table for the main flow plus
// hand-written sequences for winning, mid-match reset and disabled pause.
module tb_game_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic miss_left = 1'b0, miss_right = 1'b0;

  logic [2:0] state, state_np;
  logic       ball_enable, ball_reset, serve_dir;
  logic       ball_enable_np, ball_reset_np, serve_dir_np;
  logic [3:0] score_left, score_right, score_left_np, score_right_np;
  logic [1:0] winner, winner_np;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  game_ctl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .miss_left(miss_left), .miss_right(miss_right),
    .state(state), .ball_enable(ball_enable), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score_left(score_left), .score_right(score_right),
    .winner(winner)
  );

  game_ctl #(.PAUSE_EN(0)) dut_np (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .miss_left(miss_left), .miss_right(miss_right),
    .state(state_np), .ball_enable(ball_enable_np), .ball_reset(ball_reset_np),
    .serve_dir(serve_dir_np), .score_left(score_left_np),
    .score_right(score_right_np), .winner(winner_np)
  );

  typedef struct {
    int         n;
    logic       st, pa, ml, mr, tk;
    logic [2:0] s;
    logic       be, br, dir;
    logic [3:0] sl, sr;
    logic [1:0] w;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] s, input logic be,
                         input logic br, input logic dir, input logic [3:0] sl,
                         input logic [3:0] sr, input logic [1:0] w);
    chk({tag, ".state"}, 8'(state), 8'(s));
    chk({tag, ".ball_enable"}, 8'(ball_enable), 8'(be));
    chk({tag, ".ball_reset"}, 8'(ball_reset), 8'(br));
    chk({tag, ".serve_dir"}, 8'(serve_dir), 8'(dir));
    chk({tag, ".score_left"}, 8'(score_left), 8'(sl));
    chk({tag, ".score_right"}, 8'(score_right), 8'(sr));
    chk({tag, ".winner"}, 8'(winner), 8'(w));
  endtask

  task automatic set_in(input logic st, input logic pa, input logic ml,
                        input logic mr, input logic tk);
    start_btn = st; pause_btn = pa; miss_left = ml; miss_right = mr; frame_tick = tk;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 60 frame ticks then one quiet cycle: SERVE -> PLAY.
  task automatic serve();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(60);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1);
  endtask

  // One miss from PLAY, the POINT cycle, then a full serve back to PLAY.
  task automatic score_point(input logic ml, input logic mr);
    set_in(1'b0, 1'b0, ml, mr, 1'b0);
    cyc(1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    serve();
  endtask

  initial begin
    //                n st pa ml mr tk  s be br dir sl sr w
    vq.push_back('{ 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0});
    vq.push_back('{ 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0});
    vq.push_back('{59, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0});
    vq.push_back('{ 1, 0, 0, 0, 1, 0, 4, 0, 1, 1, 0, 0, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0});
    vq.push_back('{60, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 1, 0, 0});
    vq.push_back('{ 1, 0, 0, 1, 0, 0, 4, 0, 1, 1, 1, 0, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0});
    vq.push_back('{60, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0});
    vq.push_back('{60, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0});
    vq.push_back('{10, 0, 1, 1, 0, 1, 3, 0, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 1, 0, 0, 0, 2, 1, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 1, 0, 1, 0, 4, 0, 1, 0, 1, 1, 0});
    vq.push_back('{ 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 2, 1, 0});
    vq.push_back('{60, 0, 0, 0, 0, 1, 1, 0, 1, 1, 2, 1, 0});
    vq.push_back('{ 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 2, 1, 0});

    // Reset values while rst is held across a clock edge.
    @(negedge clk);
    chk_all("reset", 3'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      for (int c = 0; c < vq[i].n; c++) begin
        set_in(vq[i].st, vq[i].pa, vq[i].ml, vq[i].mr, vq[i].tk);
        @(negedge clk);
      end
      chk_all($sformatf("row%0d", i), vq[i].s, vq[i].be, vq[i].br, vq[i].dir,
              vq[i].sl, vq[i].sr, vq[i].w);
    end

    // Left player wins 5:1; scores move exactly two clocks after the miss.
    for (int k = 3; k <= 5; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("win%0d.lat1_score", k), 8'(score_left), 8'(k - 1));
      cyc(1);
      chk($sformatf("win%0d.lat2_score", k), 8'(score_left), 8'(k));
      if (k < 5) begin
        chk($sformatf("win%0d.state", k), 8'(state), 8'd1);
        serve();
      end
    end
    chk_all("over", 3'd5, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 2'd1);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(3);
    chk_all("over_hold", 3'd5, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 2'd1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_all("restart", 3'd1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Build 3:2 in PLAY, then reset asynchronously between clock edges.
    serve();
    score_point(1'b0, 1'b1);
    score_point(1'b0, 1'b1);
    score_point(1'b0, 1'b1);
    score_point(1'b1, 1'b0);
    score_point(1'b1, 1'b0);
    chk_all("pre_rst", 3'd2, 1'b1, 1'b0, 1'b0, 4'd3, 4'd2, 2'd0);
    start_btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk_all("held_start", 3'd0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0);
    start_btn = 1'b0;
    cyc(1);
    start_btn = 1'b1;
    cyc(1);
    chk("new_start.state", 8'(state), 8'd1);
    start_btn = 1'b0;

    // Both instances reach PLAY together; only the pause-enabled one pauses.
    serve();
    chk("np_play.state", 8'(state_np), 8'd2);
    pause_btn = 1'b1;
    cyc(1);
    chk("np_pause1.state", 8'(state_np), 8'd2);
    chk("np_pause1.ball_enable", 8'(ball_enable_np), 8'd1);
    chk("en_pause1.state", 8'(state), 8'd3);
    pause_btn = 1'b0;
    cyc(1);
    pause_btn = 1'b1;
    cyc(1);
    chk("np_pause2.state", 8'(state_np), 8'd2);
    chk("en_pause2.state", 8'(state), 8'd2);
    pause_btn = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
